// File: rtl/cart_flash_arbiter_if.sv
// Flash-bus sharing interface: Game Boy and auxiliary read ports plus
// the parallel flash pins, bundled for the arbiter.
interface cart_flash_arbiter_if #(
  parameter int unsigned AW = 24
);
  logic          gb_req;
  logic [14:0]   gb_addr;
  logic          gb_ack;
  logic [7:0]    gb_rdata;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_ack;
  logic [15:0]   aux_rdata;
  logic [AW-1:0] flash_a;
  logic [15:0]   flash_d;
  logic          flash_ce_b;
  logic          flash_oe_b;
  logic          flash_adv_b;
  logic          flash_we_b;
  logic          busy;

  modport master (
    output gb_req, gb_addr, aux_req, aux_addr, flash_d,
    input  gb_ack, gb_rdata, aux_ack, aux_rdata,
    input  flash_a, flash_ce_b, flash_oe_b,
    input  flash_adv_b, flash_we_b, busy
  );

  modport slave (
    input  gb_req, gb_addr, aux_req, aux_addr, flash_d,
    output gb_ack, gb_rdata, aux_ack, aux_rdata,
    output flash_a, flash_ce_b, flash_oe_b,
    output flash_adv_b, flash_we_b, busy
  );
endinterface

// File: rtl/cart_flash_arbiter.sv
// Round-robin arbiter sequencing flash reads for the Game Boy
// cartridge fetch port and the auxiliary debug/loader port.
module cart_flash_arbiter #(
  parameter int unsigned   WAIT_CYCLES = 4,
  parameter int unsigned   AW          = 24,
  parameter logic [AW-1:0] GB_BASE     = 24'h000104
) (
  input logic clk,
  input logic rst,
  cart_flash_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_RECOVER
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_last;
  logic [AW-1:0] r_a;
  logic [7:0]    r_gb_rdata;
  logic [15:0]   r_aux_rdata;
  logic          r_gb_ack;
  logic          r_aux_ack;
  logic          r_ce_b;
  logic          r_oe_b;
  logic          r_adv_b;
  logic          r_busy;

  logic          w_gnt_gb;
  logic          w_gnt_aux;
  logic          w_grant;
  logic [AW-1:0] w_gb_a;
  logic          w_ce_b;
  logic          w_oe_b;
  logic          w_adv_b;
  logic          w_busy;
  logic          w_gb_ack;
  logic          w_aux_ack;

  // r_last = 1 means the auxiliary port was served last
  assign w_gnt_gb  = bus.gb_req & (~bus.aux_req | r_last);
  assign w_gnt_aux = bus.aux_req & (~bus.gb_req | ~r_last);
  assign w_grant   = w_gnt_gb | w_gnt_aux;
  assign w_gb_a    = {{(AW-15){1'b0}}, bus.gb_addr} + GB_BASE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_grant) w_next = S_ADDR;
      S_ADDR:    w_next = S_WAIT;
      S_WAIT:    if (r_cnt == 4'd0) w_next = S_DATA;
      S_DATA:    w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes and acks are decoded from the next state so they register
  // in the same cycle the FSM enters that state.
  always_comb begin
    w_ce_b    = 1'b1;
    w_oe_b    = 1'b1;
    w_adv_b   = 1'b1;
    w_busy    = (w_next != S_IDLE);
    w_gb_ack  = 1'b0;
    w_aux_ack = 1'b0;
    unique case (w_next)
      S_ADDR: begin
        w_ce_b  = 1'b0;
        w_adv_b = 1'b0;
      end
      S_WAIT: begin
        w_ce_b = 1'b0;
        w_oe_b = 1'b0;
      end
      S_DATA: begin
        w_ce_b    = 1'b0;
        w_oe_b    = 1'b0;
        w_gb_ack  = ~r_last;
        w_aux_ack = r_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_a         <= '0;
      r_gb_rdata  <= 8'h00;
      r_aux_rdata <= 16'h0000;
      r_gb_ack    <= 1'b0;
      r_aux_ack   <= 1'b0;
      r_ce_b      <= 1'b1;
      r_oe_b      <= 1'b1;
      r_adv_b     <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_grant) begin
        r_last <= w_gnt_aux;
        r_a    <= w_gnt_aux ? bus.aux_addr : w_gb_a;
      end
      if (r_state == S_ADDR)
        r_cnt <= 4'(WAIT_CYCLES - 1);
      else if (r_state == S_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == S_WAIT && r_cnt == 4'd0) begin
        if (r_last) r_aux_rdata <= bus.flash_d;
        else        r_gb_rdata  <= bus.flash_d[7:0];
      end
      r_gb_ack  <= w_gb_ack;
      r_aux_ack <= w_aux_ack;
      r_ce_b    <= w_ce_b;
      r_oe_b    <= w_oe_b;
      r_adv_b   <= w_adv_b;
      r_busy    <= w_busy;
    end
  end

  assign bus.gb_ack      = r_gb_ack;
  assign bus.gb_rdata    = r_gb_rdata;
  assign bus.aux_ack     = r_aux_ack;
  assign bus.aux_rdata   = r_aux_rdata;
  assign bus.flash_a     = r_a;
  assign bus.flash_ce_b  = r_ce_b;
  assign bus.flash_oe_b  = r_oe_b;
  assign bus.flash_adv_b = r_adv_b;
  assign bus.flash_we_b  = 1'b1;
  assign bus.busy        = r_busy;

endmodule
